sqr_ctrl: RTL and testbench

- Computes the 16-bit square of an 8-bit unsigned operand.
- Does not multiply itself: it drives an external shared shift-add multiplier (the codebase `mult` block) through a dedicated mul_* port group.
- Sits beside `mult` in the arithmetic datapath and exposes a start/busy handshake to the requester.

---
 rtl/sqr_ctrl.sv | 130 +++++++++++++
 tb/tb_sqr_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqr_ctrl.sv
// Squaring controller: drives a shared external shift-add multiplier with xr*xr.
// Optional macro SQR_TRIVIAL_BYPASS_EN: operands 0 and 1 complete without the multiplier.
module sqr_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  x,
  input  logic        start_i,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic        mul_start_i,
  input  logic        mul_busy_o,
  input  logic [15:0] mul_y_bo,
  output logic        busy_o,
  output logic [15:0] y_bo
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_BYPASS    = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  xr_q, xr_d;
  logic        mul_start_q, mul_start_d;
  logic        busy_q, busy_d;
  logic [15:0] y_q, y_d;

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      xr_q        <= 8'd0;
      mul_start_q <= 1'b0;
      busy_q      <= 1'b0;
      y_q         <= 16'd0;
    end else begin
      state_q     <= state_d;
      xr_q        <= xr_d;
      mul_start_q <= mul_start_d;
      busy_q      <= busy_d;
      y_q         <= y_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    xr_d        = xr_q;
    mul_start_d = 1'b0;
    busy_d      = busy_q;
    y_d         = y_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
`ifdef SQR_TRIVIAL_BYPASS_EN
          // Trivial operands never touch the multiplier, so its busy flag is irrelevant.
          if (x <= 8'd1) begin
            xr_d    = x;
            busy_d  = 1'b1;
            state_d = S_BYPASS;
          end else if (!mul_busy_o) begin
            xr_d        = x;
            mul_start_d = 1'b1;
            busy_d      = 1'b1;
            state_d     = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
`else
          if (!mul_busy_o) begin
            xr_d        = x;
            mul_start_d = 1'b1;
            busy_d      = 1'b1;
            state_d     = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_REQ: begin
        state_d = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (mul_busy_o) begin
          state_d = S_WAIT_DONE;
        end else begin
          state_d = S_WAIT_ACK;
        end
      end

      S_WAIT_DONE: begin
        if (!mul_busy_o) begin
          y_d     = mul_y_bo;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end

      S_BYPASS: begin
        y_d     = {8'd0, xr_q};
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Both multiplier operands are the latched value, held until the next accept.
  assign mul_a       = xr_q;
  assign mul_b       = xr_q;
  assign mul_start_i = mul_start_q;
  assign busy_o      = busy_q;
  assign y_bo        = y_q;

endmodule

// File: tb/tb_sqr_ctrl.sv
// Randomized self-checking bench for sqr_ctrl with a behavioural multiplier peer.
module tb_sqr_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  x;
  logic        start_i;
  logic [7:0]  mul_a, mul_b;
  logic        mul_start_i;
  logic        busy_o;
  logic [15:0] y_bo;

  logic        m_busy;
  logic [15:0] m_y, m_prod;
  int          m_cnt;
  int          lat_sel;
  logic        foreign_req;
  int          foreign_len;

  int          pulses;
  logic [7:0]  last_a, last_b;

  int          n_checks = 0;
  int          n_err    = 0;

  sqr_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .x           (x),
    .start_i     (start_i),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_start_i (mul_start_i),
    .mul_busy_o  (m_busy),
    .mul_y_bo    (m_y),
    .busy_o      (busy_o),
    .y_bo        (y_bo)
  );

  always #5 clk_i = ~clk_i;

  // Multiplier peer: latches operands on a start while idle, busy for lat_sel cycles.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_y    <= 16'd0;
      m_prod <= 16'd0;
    end else if (!m_busy) begin
      if (mul_start_i) begin
        m_busy <= 1'b1;
        m_cnt  <= lat_sel;
        m_prod <= 16'(mul_a) * 16'(mul_b);
      end else if (foreign_req) begin
        m_busy <= 1'b1;
        m_cnt  <= foreign_len;
        m_prod <= 16'hDEAD;
      end
    end else begin
      if (m_cnt <= 1) begin
        m_busy <= 1'b0;
        m_y    <= m_prod;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Start-pulse monitor.
  always @(posedge clk_i) begin
    if (mul_start_i) begin
      pulses <= pulses + 1;
      last_a <= mul_a;
      last_b <= mul_b;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_pulses(input logic [7:0] v);
`ifdef SQR_TRIVIAL_BYPASS_EN
    return (v <= 8'd1) ? 0 : 1;
`else
    return 1;
`endif
  endfunction

  // One square operation from an idle controller; x is scrambled after acceptance.
  task automatic run_op(input logic [7:0] xv, input int lat, input logic [7:0] x_after, input bit poke);
    int          cycles;
    int          p0;
    logic [15:0] y_prev;
    logic [31:0] expv;
    y_prev  = y_bo;
    p0      = pulses;
    lat_sel = lat;
    x       = xv;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check_eq("busy_rise", busy_o, 1);
    check_eq("y_hold", y_bo, y_prev);
    cycles = 1;
    while (busy_o && cycles < 20) begin
      if (cycles == 2) x = x_after;
      if (poke && (cycles == 2 || cycles == 3)) begin
        start_i = 1'b1;
        x       = 8'd3;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
      if (busy_o) check_eq("y_hold_mid", y_bo, y_prev);
      cycles++;
    end
    start_i = 1'b0;
    expv = 32'(xv) * 32'(xv);
    check_eq("latency_le14", (cycles <= 14) ? 1 : 0, 1);
    check_eq("square", y_bo, expv);
    check_eq("mul_pulses", pulses - p0, exp_pulses(xv));
    if (exp_pulses(xv) == 1) begin
      check_eq("mul_a", last_a, xv);
      check_eq("mul_b", last_b, xv);
    end else begin
      check_eq("bypass_busy_1cyc", cycles, 2);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;
    rst_i       = 1'b1;
    x           = 8'd0;
    start_i     = 1'b0;
    foreign_req = 1'b0;
    foreign_len = 6;
    lat_sel     = 8;
    pulses      = 0;
    last_a      = 8'd0;
    last_b      = 8'd0;
    @(negedge clk_i);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_y", y_bo, 0);
    check_eq("rst_mul_a", mul_a, 0);
    check_eq("rst_mul_start", mul_start_i, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    run_op(8'd0, 8, 8'd0, 1'b0);
    repeat (12) @(negedge clk_i);
    check_eq("zero_idle_busy", busy_o, 0);
    check_eq("zero_idle_y", y_bo, 0);

    run_op(8'd255, 8, 8'd17, 1'b0);
    run_op(8'd54, 8, 8'd7, 1'b0);
    run_op(8'd100, 9, 8'd3, 1'b1);

    // Reset while the multiplier is busy in WAIT_DONE.
    lat_sel = 9;
    x       = 8'd200;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check_eq("pre_rst_busy", busy_o, 1);
    rst_i = 1'b1;
    #1;
    check_eq("midrst_y", y_bo, 0);
    check_eq("midrst_busy", busy_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    run_op(8'd12, 8, 8'd99, 1'b0);

    // Start while the multiplier serves another client must be ignored.
    foreign_req = 1'b1;
    @(negedge clk_i);
    foreign_req = 1'b0;
    x       = 8'd9;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check_eq("ign_mulbusy", busy_o, 0);
`ifdef SQR_TRIVIAL_BYPASS_EN
    x       = 8'd1;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check_eq("byp_mulbusy_acc", busy_o, 1);
    @(negedge clk_i);
    check_eq("byp_mulbusy_y", y_bo, 1);
`endif
    wait_cnt = 0;
    while (m_busy && wait_cnt < 20) begin
      @(negedge clk_i);
      wait_cnt++;
    end
    check_eq("foreign_done", m_busy, 0);
    run_op(8'd9, 5, 8'd200, 1'b0);
    run_op(8'd1, 8, 8'd50, 1'b0);

    // Back-to-back randomized operations.
    for (int i = 0; i < 25; i++) begin
      run_op(8'($urandom_range(0, 255)), $urandom_range(1, 10), 8'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
